// File: rtl/fp_pkg.sv
// Shared floating-point constants, class encoding and helper functions for the
// pipelined arithmetic blocks.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 7;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Word-wide constants are built 64 bits wide; callers keep the low W bits.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w + man_w; i++) begin
            r[i] = 1'b1;
        end
        r[man_w] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined multiplier; master drives
// operands and result-ready, slave is the multiplier.
interface fp_mul_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p;
    logic         flag_inv;
    logic         flag_ovf;
    logic         flag_unf;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, p, flag_inv, flag_ovf, flag_unf
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, p, flag_inv, flag_ovf, flag_unf
    );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational normalise/round/pack of a raw mantissa product and biased
// exponent into a finite result, with overflow saturation and flush-to-zero.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                     sign_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic [2*MAN_W+1:0]       prod_i,
    input  logic                     rnd_mode_i,
    output logic [EXP_W+MAN_W:0]     res_o,
    output logic                     ovf_o,
    output logic                     unf_o
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] EMAX_S = EW'(fp_emax(EXP_W));
    localparam logic signed [EW-1:0] EZERO_S = '0;
    localparam logic [63:0] MAXF_WIDE = fp_max_finite(EXP_W, MAN_W);
    localparam logic [W-1:0] MAXF = MAXF_WIDE[W-1:0];

    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       kept;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W:0]         kept_rnd;
    logic signed [EW-1:0]   exp_n;
    logic signed [EW-1:0]   exp_r;

    always_comb begin
        // Leading one is dropped: either the product MSB or, after a 1-bit shift, the next bit.
        norm     = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
        exp_n    = exp_i + $signed({{(EW-1){1'b0}}, prod_i[PW-1]});
        kept     = norm[2*MAN_W:MAN_W+1];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = (rnd_mode_i == RND_RNE) & guard & (sticky | kept[0]);
        kept_rnd = {1'b0, kept} + {{MAN_W{1'b0}}, round_up};
        exp_r    = exp_n + $signed({{(EW-1){1'b0}}, kept_rnd[MAN_W]});

        ovf_o = 1'b0;
        unf_o = 1'b0;
        res_o = {sign_i, exp_r[EXP_W-1:0], kept_rnd[MAN_W-1:0]};
        if (exp_r >= EMAX_S) begin
            ovf_o = 1'b1;
            if (rnd_mode_i == RND_RNE) begin
                res_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                res_o = {sign_i, MAXF[W-2:0]};
            end
        end else if (exp_r <= EZERO_S) begin
            unf_o = 1'b1;
            res_o = {sign_i, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: registered operands, decode, mantissa
// product and normalise/round/pack, all advancing together under one stall.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));
    localparam logic [63:0] QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_WIDE[W-1:0];

    logic en;

    logic         v0_q;
    logic [W-1:0] a0_q;
    logic [W-1:0] b0_q;
    logic         rnd0_q;

    logic                 v1_q;
    logic                 sign1_q;
    logic                 rnd1_q;
    logic signed [EW-1:0] esum1_q;
    logic [MAN_W:0]       ma1_q;
    logic [MAN_W:0]       mb1_q;
    fp_class_e            cls_a1_q;
    fp_class_e            cls_b1_q;

    logic                 v2_q;
    logic                 sign2_q;
    logic                 rnd2_q;
    logic signed [EW-1:0] esum2_q;
    logic [PW-1:0]        pr2_q;
    fp_class_e            cls_a2_q;
    fp_class_e            cls_b2_q;

    logic         out_valid_q;
    logic [W-1:0] p_q;
    logic         inv_q;
    logic         ovf_q;
    logic         unf_q;

    logic                 sign1_d;
    logic signed [EW-1:0] esum1_d;
    logic [PW-1:0]        pr2_d;
    logic [W-1:0]         p3_d;
    logic                 inv3_d;
    logic                 ovf3_d;
    logic                 unf3_d;

    logic [W-1:0] rp_res;
    logic         rp_ovf;
    logic         rp_unf;

    logic [1:0][W-1:0] opnd;

    // A result can only leave when the consumer takes it, so the whole pipe stalls together.
    assign en           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = en;

    assign opnd = {b0_q, a0_q};

    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
        logic [EXP_W-1:0] e_fld;
        logic [MAN_W-1:0] m_fld;
        logic [MAN_W:0]   man;
        fp_class_e        cls;

        assign e_fld = opnd[gi][W-2:MAN_W];
        assign m_fld = opnd[gi][MAN_W-1:0];

        // Zero exponent covers subnormals too: they are treated as zero.
        always_comb begin
            cls = CLS_NORM;
            if (e_fld == '0) begin
                cls = CLS_ZERO;
            end else if (e_fld == '1) begin
                cls = (m_fld == '0) ? CLS_INF : CLS_NAN;
            end
        end

        assign man = {cls == CLS_NORM, m_fld};
    end

    assign sign1_d = a0_q[W-1] ^ b0_q[W-1];
    assign esum1_d = $signed({2'b00, g_dec[0].e_fld}) + $signed({2'b00, g_dec[1].e_fld}) - BIAS_S;

    assign pr2_d = {{(MAN_W+1){1'b0}}, ma1_q} * {{(MAN_W+1){1'b0}}, mb1_q};

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i     (sign2_q),
        .exp_i      (esum2_q),
        .prod_i     (pr2_q),
        .rnd_mode_i (rnd2_q),
        .res_o      (rp_res),
        .ovf_o      (rp_ovf),
        .unf_o      (rp_unf)
    );

    always_comb begin
        p3_d   = rp_res;
        inv3_d = 1'b0;
        ovf3_d = rp_ovf;
        unf3_d = rp_unf;
        if ((cls_a2_q == CLS_NAN) || (cls_b2_q == CLS_NAN) ||
            ((cls_a2_q == CLS_INF) && (cls_b2_q == CLS_ZERO)) ||
            ((cls_a2_q == CLS_ZERO) && (cls_b2_q == CLS_INF))) begin
            p3_d   = QNAN;
            inv3_d = 1'b1;
            ovf3_d = 1'b0;
            unf3_d = 1'b0;
        end else if ((cls_a2_q == CLS_INF) || (cls_b2_q == CLS_INF)) begin
            p3_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf3_d = 1'b0;
            unf3_d = 1'b0;
        end else if ((cls_a2_q == CLS_ZERO) || (cls_b2_q == CLS_ZERO)) begin
            p3_d   = {sign2_q, {(W-1){1'b0}}};
            ovf3_d = 1'b0;
            unf3_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            a0_q        <= '0;
            b0_q        <= '0;
            rnd0_q      <= 1'b0;
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            rnd1_q      <= 1'b0;
            esum1_q     <= '0;
            ma1_q       <= '0;
            mb1_q       <= '0;
            cls_a1_q    <= CLS_ZERO;
            cls_b1_q    <= CLS_ZERO;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            rnd2_q      <= 1'b0;
            esum2_q     <= '0;
            pr2_q       <= '0;
            cls_a2_q    <= CLS_ZERO;
            cls_b2_q    <= CLS_ZERO;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (en) begin
            v0_q        <= bus.in_valid;
            a0_q        <= bus.a;
            b0_q        <= bus.b;
            rnd0_q      <= bus.rnd_mode;

            v1_q        <= v0_q;
            sign1_q     <= sign1_d;
            rnd1_q      <= rnd0_q;
            esum1_q     <= esum1_d;
            ma1_q       <= g_dec[0].man;
            mb1_q       <= g_dec[1].man;
            cls_a1_q    <= g_dec[0].cls;
            cls_b1_q    <= g_dec[1].cls;

            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            rnd2_q      <= rnd1_q;
            esum2_q     <= esum1_q;
            pr2_q       <= pr2_d;
            cls_a2_q    <= cls_a1_q;
            cls_b2_q    <= cls_b1_q;

            out_valid_q <= v2_q;
            p_q         <= p3_d;
            inv_q       <= inv3_d;
            ovf_q       <= ovf3_d;
            unf_q       <= unf3_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.flag_inv  = inv_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_unf  = unf_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe in bf16 configuration: directed vectors,
// backpressure streaming, random operands and reset with results in flight.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(7)) bus_if ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [18:0] want;     // {inv, ovf, unf, p}
        int          acc_cyc;
        bit          lat_chk;
    } txn_t;

    txn_t sb_q[$];
    txn_t mon_t;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   ready_mode = 0;
    int   mode_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: integer product, explicit remainder-vs-half rounding decision.
    function automatic logic [18:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic rm);
        int ex, ey, fx, fy, e, q, rem, half, sh, prod;
        logic s;
        bit nan_x, nan_y, inf_x, inf_y;
        s  = x[15] ^ y[15];
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        fx = int'(x[6:0]);
        fy = int'(y[6:0]);
        nan_x = (ex == 255) && (fx != 0);
        nan_y = (ey == 255) && (fy != 0);
        inf_x = (ex == 255) && (fx == 0);
        inf_y = (ey == 255) && (fy == 0);
        if (nan_x || nan_y) return {3'b100, 16'h7FC0};
        if ((inf_x && ey == 0) || (inf_y && ex == 0)) return {3'b100, 16'h7FC0};
        if (inf_x || inf_y) return {3'b000, s, 8'hFF, 7'h00};
        if (ex == 0 || ey == 0) return {3'b000, s, 15'h0000};
        prod = (128 + fx) * (128 + fy);
        e = ex + ey - 127;
        if (prod >= 32768) begin
            sh = 8;
            e++;
        end else begin
            sh = 7;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 1 << (sh - 1);
        if (!rm && ((rem > half) || (rem == half && (q % 2) == 1))) q++;
        if (q == 256) begin
            q = 128;
            e++;
        end
        if (e >= 255) return rm ? {3'b010, s, 8'hFE, 7'h7F} : {3'b010, s, 8'hFF, 7'h00};
        if (e <= 0) return {3'b001, s, 15'h0000};
        return {3'b000, s, e[7:0], q[6:0]};
    endfunction

    // Called and returns just after a rising edge; holds operands until accepted.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic trnd,
                        input logic [18:0] want, input bit lat);
        txn_t t;
        int   waits;
        bus_if.in_valid = 1'b1;
        bus_if.a        = ta;
        bus_if.b        = tb;
        bus_if.rnd_mode = trnd;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus_if.in_ready) break;
            waits++;
            if (waits > 100) break;
        end
        if (bus_if.in_ready) begin
            t.a       = ta;
            t.b       = tb;
            t.rnd     = trnd;
            t.want    = want;
            t.acc_cyc = cyc + 1;
            t.lat_chk = lat;
            sb_q.push_back(t);
        end else begin
            check("in_ready_timeout", 32'(bus_if.in_ready), 1);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Result sink: always ready, or random with a forced 5-cycle low window.
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                mode_cyc = 0;
                bus_if.out_ready = 1'b1;
            end else begin
                mode_cyc++;
                if (mode_cyc >= 4 && mode_cyc < 9) bus_if.out_ready = 1'b0;
                else bus_if.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_if.out_valid && !bus_if.out_ready)
                    check("stall_in_ready", 32'(bus_if.in_ready), 0);
                if (bus_if.out_valid && bus_if.out_ready) begin
                    check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        mon_t = sb_q.pop_front();
                        n_out++;
                        $display("out #%0d: %h * %h rnd=%0d -> p=%h inv=%0d ovf=%0d unf=%0d (want %h flags %b)",
                                 n_out, mon_t.a, mon_t.b, mon_t.rnd, bus_if.p, bus_if.flag_inv,
                                 bus_if.flag_ovf, bus_if.flag_unf, mon_t.want[15:0], mon_t.want[18:16]);
                        check("p", 32'(bus_if.p), 32'(mon_t.want[15:0]));
                        check("flags", 32'({bus_if.flag_inv, bus_if.flag_ovf, bus_if.flag_unf}),
                              32'(mon_t.want[18:16]));
                        if (mon_t.lat_chk) check("latency", 32'(cyc - mon_t.acc_cyc), 3);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    logic [15:0] dir_a [14] = '{16'h3F80, 16'h3FC0, 16'h3F81, 16'h3F81, 16'h7F00, 16'h7F00, 16'h0080,
                                16'h7F80, 16'hFF80, 16'h7FC1, 16'h0001, 16'h0000, 16'h8001, 16'hBF80};
    logic [15:0] dir_b [14] = '{16'h3F80, 16'h3FC0, 16'h4040, 16'h4040, 16'h4000, 16'h4000, 16'h0080,
                                16'h0000, 16'h3F80, 16'h3F80, 16'h3F80, 16'hFF80, 16'h3F80, 16'h4000};
    logic        dir_r [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [18:0] dir_e [14] = '{{3'b000, 16'h3F80}, {3'b000, 16'h4010}, {3'b000, 16'h4042},
                                {3'b000, 16'h4041}, {3'b010, 16'h7F80}, {3'b010, 16'h7F7F},
                                {3'b001, 16'h0000}, {3'b100, 16'h7FC0}, {3'b000, 16'hFF80},
                                {3'b100, 16'h7FC0}, {3'b000, 16'h0000}, {3'b100, 16'h7FC0},
                                {3'b000, 16'h8000}, {3'b000, 16'hC000}};

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rr;
        int          n0;
        bus_if.in_valid = 1'b0;
        bus_if.a        = '0;
        bus_if.b        = '0;
        bus_if.rnd_mode = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus_if.out_valid), 0);
        check("rst_p", 32'(bus_if.p), 0);
        check("rst_flags", 32'({bus_if.flag_inv, bus_if.flag_ovf, bus_if.flag_unf}), 0);
        check("rst_in_ready", 32'(bus_if.in_ready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) send(dir_a[i], dir_b[i], dir_r[i], dir_e[i], 1'b1);
        drain("drain_directed");

        // Backpressure: 8 back-to-back operand pairs against a random sink.
        n0 = n_out;
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom_range(0, 127))};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom_range(0, 127))};
            rr = 1'($urandom_range(0, 1));
            send(ra, rb, rr, ref_mul(ra, rb, rr), 1'b0);
        end
        drain("drain_backpressure");
        ready_mode = 0;
        check("bp_count", 32'(n_out - n0), 8);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rr = 1'($urandom_range(0, 1));
            send(ra, rb, rr, ref_mul(ra, rb, rr), 1'b1);
        end
        drain("drain_random");

        // Reset with three results in flight: none of them may appear.
        n0 = n_out;
        send(16'h3F80, 16'h4000, 1'b0, 19'h0, 1'b0);
        send(16'h4040, 16'h4040, 1'b0, 19'h0, 1'b0);
        send(16'hC000, 16'h3FC0, 1'b0, 19'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(bus_if.out_valid), 0);
        check("flush_p", 32'(bus_if.p), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_idle", 32'(bus_if.out_valid), 0);
        end
        check("flush_count", 32'(n_out - n0), 0);
        @(posedge clk);
        #1;
        send(16'h4040, 16'h3FC0, 1'b0, {3'b000, 16'h4090}, 1'b1);
        drain("drain_after_reset");
        check("post_rst_count", 32'(n_out - n0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
